// File: rtl/crypto_wallet_seed_collector.sv
// Entropy seed collector: Avalon-MM read master that pulls 32-bit words
// from the PIO entropy source and packs them into a WORDS*32-bit seed.
// A repetition-count health test discards duplicates and aborts on a
// run of MAX_REPEAT identical samples. The seed is handed over through a
// valid/ready handshake and wiped once it has been consumed.
module crypto_wallet_seed_collector #(
    parameter int          WORDS      = 8,
    parameter logic [1:0]  PIO_ADDR   = 2'd0,
    parameter int          MAX_REPEAT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [1:0]            avm_address,
    output logic                  avm_read,
    input  logic [31:0]           avm_readdata,
    output logic [32*WORDS-1:0]   seed,
    output logic                  seed_valid,
    input  logic                  seed_ready,
    output logic                  busy,
    output logic                  error
);

    localparam int SW = 32 * WORDS;
    localparam int CW = $clog2(WORDS + 1);
    localparam int RW = $clog2(MAX_REPEAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAPT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   rep_q;
    logic [31:0]     prev_q;
    logic            have_prev_q;
    logic [SW-1:0]   seed_q;
    logic            seed_valid_q;
    logic            busy_q;
    logic            error_q;
    logic            avm_read_q;

    logic            dup_d;
    logic [CW-1:0]   cnt_d;
    logic [RW-1:0]   rep_d;
    logic            rep_fail_d;
    logic            cnt_full_d;

    // Health-test decode for the sample currently on the read data bus.
    always_comb begin
        dup_d      = have_prev_q && (avm_readdata == prev_q);
        cnt_d      = cnt_q + CW'(1);
        rep_d      = rep_q + RW'(1);
        rep_fail_d = (rep_d == RW'(MAX_REPEAT));
        cnt_full_d = (cnt_d == CW'(WORDS));
    end

    // Collection FSM; every output is registered here. avm_read is raised
    // on entry to REQ so the read strobe occupies exactly the REQ cycle and
    // the data is sampled one cycle later on leaving CAPT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rep_q        <= '0;
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
            seed_q       <= '0;
            seed_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            avm_read_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FAIL: begin
                    if (start) begin
                        state_q     <= S_REQ;
                        avm_read_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        error_q     <= 1'b0;
                        cnt_q       <= '0;
                        rep_q       <= '0;
                        prev_q      <= '0;
                        have_prev_q <= 1'b0;
                    end
                end

                S_REQ: begin
                    avm_read_q <= 1'b0;
                    state_q    <= S_CAPT;
                end

                S_CAPT: begin
                    if (dup_d) begin
                        // Duplicate sample: dropped, only the run length grows.
                        rep_q <= rep_d;
                        if (rep_fail_d) begin
                            state_q <= S_FAIL;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                            seed_q  <= '0;
                        end else begin
                            state_q    <= S_REQ;
                            avm_read_q <= 1'b1;
                        end
                    end else begin
                        for (int k = 0; k < WORDS; k++) begin
                            if (cnt_q == CW'(k))
                                seed_q[32*k +: 32] <= avm_readdata;
                        end
                        cnt_q       <= cnt_d;
                        rep_q       <= RW'(1);
                        prev_q      <= avm_readdata;
                        have_prev_q <= 1'b1;
                        if (cnt_full_d) begin
                            state_q      <= S_DONE;
                            seed_valid_q <= 1'b1;
                            busy_q       <= 1'b0;
                        end else begin
                            state_q    <= S_REQ;
                            avm_read_q <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    if (seed_ready) begin
                        state_q      <= S_IDLE;
                        seed_valid_q <= 1'b0;
                        seed_q       <= '0;
                        prev_q       <= '0;
                        have_prev_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    avm_read_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address = PIO_ADDR;
    assign avm_read    = avm_read_q;
    assign seed        = seed_q;
    assign seed_valid  = seed_valid_q;
    assign busy        = busy_q;
    assign error       = error_q;

endmodule
